// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Sequential instruction fetcher with a credit-limited FIFO
//               queue, branch redirect/squash and misaligned-target flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_target,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic [ADDR_W-1:0]          link_addr,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       misalign_err
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W+1:0]  DEPTH_C = (PTR_W+2)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              in_flight;
    logic [PTR_W:0]    count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              misalign_q;
    logic [31:0]       q_instr [DEPTH];
    logic [ADDR_W-1:0] q_pc    [DEPTH];
    logic [PTR_W+1:0]  credits;
    logic              push;
    logic              pop;

    // Outstanding response counts against queue space so it can never overflow.
    assign credits   = {1'b0, count} + {{(PTR_W+1){1'b0}}, in_flight};
    assign imem_req  = !reset && !redirect_valid && (credits < DEPTH_C);
    assign imem_addr = fetch_pc;

    assign instr_valid = (count != '0);
    assign push        = in_flight && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc   <= RESET_VEC;
            req_pc     <= '0;
            in_flight  <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && (redirect_target[1:0] != 2'b00);
            in_flight  <= imem_req;
            if (redirect_valid) begin
                fetch_pc <= {redirect_target[ADDR_W-1:2], 2'b00};
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (imem_req) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                    req_pc   <= fetch_pc;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + (PTR_W+1)'(1);
                end else if (pop && !push) begin
                    count <= count - (PTR_W+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= req_pc;
        end
    end

    assign instr        = q_instr[rd_ptr];
    assign instr_pc     = q_pc[rd_ptr];
    assign link_addr    = instr_pc + ADDR_W'(4);
    assign occupancy    = count;
    assign misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Randomized bench for ifetch_queue against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    localparam int AW  = 16;
    localparam int DEP = 4;

    logic          clock;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic [AW-1:0] link_addr;
    logic [2:0]    occupancy;
    logic          misalign_err;

    ifetch_queue #(.ADDR_W(AW), .DEPTH(DEP), .RESET_VEC(16'h0000)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .link_addr(link_addr), .occupancy(occupancy),
        .misalign_err(misalign_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // staged stimulus, applied at the next falling edge
    logic          s_reset = 1'b1;
    logic          s_redir = 1'b0;
    logic [AW-1:0] s_tgt   = '0;
    logic          s_ready = 1'b1;

    logic          prev_req  = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] dq[$];

    // reference model: fetch pointer, FIFO of PCs, one outstanding request
    logic [AW-1:0] m_fetch = '0;
    logic [AW-1:0] m_ifpc  = '0;
    logic [AW-1:0] m_q[$];
    bit            m_inf   = 0;
    bit            m_mis   = 0;
    bit            m_init  = 0;
    bit            exp_req;

    function automatic logic [31:0] rom(input logic [AW-1:0] a);
        return {18'd0, a[AW-1:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(negedge clock);
        reset           = s_reset;
        redirect_valid  = s_redir;
        redirect_target = s_tgt;
        instr_ready     = s_ready;
        imem_rdata      = prev_req ? rom(prev_addr) : $urandom();
        #1;
        exp_req = !reset && !redirect_valid && ((m_q.size() + int'(m_inf)) < DEP);
        if (m_init) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_fetch});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_q.size() != 0});
            chk("occupancy", {29'd0, occupancy}, 32'(m_q.size()));
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
            if (m_q.size() != 0) begin
                chk("instr", instr, rom(m_q[0]));
                chk("instr_pc", {16'd0, instr_pc}, {16'd0, m_q[0]});
                chk("link_addr", {16'd0, link_addr}, {16'd0, m_q[0] + 16'd4});
            end
        end
        if (instr_valid && instr_ready && !reset && !redirect_valid) dq.push_back(instr_pc);
        prev_req  = imem_req;
        prev_addr = imem_addr;
        if (reset) begin
            m_init  = 1;
            m_fetch = 16'h0000;
            m_q.delete();
            m_inf   = 0;
            m_mis   = 0;
        end else begin
            m_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
            if (redirect_valid) begin
                m_q.delete();
                m_inf   = 0;
                m_fetch = {redirect_target[AW-1:2], 2'b00};
            end else begin
                if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
                if (m_inf) m_q.push_back(m_ifpc);
                m_inf = exp_req;
                if (exp_req) begin
                    m_ifpc  = m_fetch;
                    m_fetch = m_fetch + 16'd4;
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  nreq;
        bit  found;
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        instr_ready = 1'b1; imem_rdata = '0;
        cycle(); cycle();

        // sequential fetch from reset vector
        s_reset = 0; s_ready = 1;
        cycle(); chk("A_req0", {31'd0, imem_req}, 1); chk("A_addr0", {16'd0, imem_addr}, 0);
        cycle(); chk("A_addr1", {16'd0, imem_addr}, 4); chk("A_valid1", {31'd0, instr_valid}, 0);
        cycle(); chk("A_valid2", {31'd0, instr_valid}, 1); chk("A_pc2", {16'd0, instr_pc}, 0);
                 chk("A_link2", {16'd0, link_addr}, 4); chk("A_addr2", {16'd0, imem_addr}, 8);
        cycle(); chk("A_pc3", {16'd0, instr_pc}, 4); chk("A_link3", {16'd0, link_addr}, 8);
                 chk("A_instr3", instr, 1);

        // back-pressure fills the queue, then drains in order
        s_reset = 1; cycle();
        s_reset = 0; s_ready = 0; nreq = 0;
        repeat (8) begin cycle(); if (imem_req) nreq++; end
        chk("B_nreq", nreq, 4); chk("B_occ", {29'd0, occupancy}, 4);
        chk("B_req", {31'd0, imem_req}, 0);
        dq.delete(); s_ready = 1;
        repeat (5) cycle();
        chk("B_npop", dq.size(), 5);
        for (int i = 0; i < 5; i++) chk("B_pop_pc", (i < dq.size()) ? {16'd0, dq[i]} : 32'hFFFF_FFFF, 32'(i * 4));

        // redirect with 3 queued and 1 in flight
        s_reset = 1; cycle();
        s_reset = 0; s_ready = 0;
        repeat (4) cycle();
        s_redir = 1; s_tgt = 16'h0100;
        cycle(); chk("C_occ_pre", {29'd0, occupancy}, 3);
        s_redir = 0; s_ready = 1; dq.delete();
        cycle(); chk("C_occ0", {29'd0, occupancy}, 0); chk("C_addr", {16'd0, imem_addr}, 32'h100);
                 chk("C_req", {31'd0, imem_req}, 1);
        for (int i = 0; i < 10 && dq.size() == 0; i++) cycle();
        chk("C_first", (dq.size() != 0) ? {16'd0, dq[0]} : 32'hFFFF_FFFF, 32'h100);

        // misaligned redirect target
        s_redir = 1; s_tgt = 16'h0103;
        cycle(); s_redir = 0;
        cycle(); chk("D_mis", {31'd0, misalign_err}, 1); chk("D_addr", {16'd0, imem_addr}, 32'h100);
        cycle(); chk("D_mis_clr", {31'd0, misalign_err}, 0);

        // address wrap at top of 16-bit space
        s_redir = 1; s_tgt = 16'hFFF8;
        cycle(); s_redir = 0;
        cycle(); chk("E_a0", {16'd0, imem_addr}, 32'hFFF8);
        cycle(); chk("E_a1", {16'd0, imem_addr}, 32'hFFFC);
        cycle(); chk("E_a2", {16'd0, imem_addr}, 32'h0000);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (instr_valid && instr_pc == 16'hFFFC) begin
                found = 1;
                chk("E_link", {16'd0, link_addr}, 0);
            end
        end
        chk("E_found", {31'd0, found}, 1);

        // reset mid-operation
        s_reset = 1; cycle();
        s_reset = 0; s_ready = 0;
        repeat (3) cycle();
        s_reset = 1;
        cycle(); chk("F_occ_pre", {29'd0, occupancy}, 2);
        s_reset = 0; s_ready = 1;
        cycle(); chk("F_valid", {31'd0, instr_valid}, 0); chk("F_occ", {29'd0, occupancy}, 0);
                 chk("F_addr", {16'd0, imem_addr}, 0); chk("F_req", {31'd0, imem_req}, 1);

        // randomized traffic
        repeat (3000) begin
            s_ready = ($urandom_range(9) < 7);
            s_redir = ($urandom_range(19) == 0);
            s_tgt   = ($urandom_range(3) == 0) ? 16'(16'hFFF0 + $urandom_range(15)) : 16'($urandom());
            s_reset = ($urandom_range(99) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
